// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one shared full adder (two half adders + OR) walks
// WIDTH bit positions LSB first. Define SERIAL_ADD_SUB_EN to add a subtract input.

module half_adder (
    input  logic i_x,
    input  logic i_y,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_x ^ i_y;
    assign o_c = i_x & i_y;
endmodule

module or_gate (
    input  logic i_x,
    input  logic i_y,
    output logic o_z
);
    assign o_z = i_x | i_y;
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);
    localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [IDX_W-1:0] r_idx;

    logic w_accept;
    logic w_last;
    logic w_sub;
    logic w_s0;
    logic w_c0;
    logic w_bit;
    logic w_c1;
    logic w_cout;

`ifdef SERIAL_ADD_SUB_EN
    assign w_sub = sub;
`else
    assign w_sub = 1'b0;
`endif

    // Shared full-adder cell fed from the operand shift-register LSBs.
    half_adder u_ha0 (.i_x(r_a[0]), .i_y(r_b[0]), .o_s(w_s0), .o_c(w_c0));
    half_adder u_ha1 (.i_x(w_s0), .i_y(r_carry), .o_s(w_bit), .o_c(w_c1));
    or_gate    u_or  (.i_x(w_c0), .i_y(w_c1), .o_z(w_cout));

    assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;
    assign w_last   = (r_state == S_RUN) && (r_idx == IDX_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  w_state_next = start ? S_RUN : S_IDLE;
            S_RUN:   w_state_next = w_last ? S_DONE : S_RUN;
            S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_RUN);
        done = (r_state == S_DONE);
    end

    // Subtraction is a + ~b + 1, so the carry register doubles as the +1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= w_sub ? ~b : b;
            r_carry <= w_sub;
            r_idx   <= '0;
        end else if (r_state == S_RUN) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_res   <= {w_bit, r_res[WIDTH-1:1]};
            r_carry <= w_cout;
            r_idx   <= r_idx + IDX_W'(1);
            if (w_last) begin
                r_sum  <= {w_bit, r_res[WIDTH-1:1]};
                r_cout <= w_cout;
            end
        end
    end

    assign sum   = r_sum;
    assign c_out = r_cout;

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder controller: it time-shares a single 1-bit full adder, built from two `half_adder` instances and one `or_gate`, across all WIDTH bit positions of an operand pair. It processes one bit per clock, LSB first. It sits between a requester issuing `start` with operands and a consumer that samples `sum`/`c_out` on the `done` pulse. It is the team's first sequential block over the structural gate library and trades WIDTH cycles of latency for one adder cell.

## Interface
- `WIDTH`, default 8: operand/result width in bits; legal range 2..32.

- `clk` input 1: single clock; all state changes on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: request; sampled only in IDLE or DONE.
- `a` input WIDTH: operand A; captured at the accepting edge.
- `b` input WIDTH: operand B; captured at the accepting edge.
- `busy` output 1: high while in RUN.
- `done` output 1: one-cycle pulse in DONE; result valid.
- `sum` output WIDTH: result register.
- `c_out` output 1: final carry out of bit WIDTH-1.

## Operation
- FSM states:
  - IDLE (reset state).
  - RUN: bit index `idx` runs 0..WIDTH-1.
  - DONE.
- IDLE: `start`=1 accepts the request. Latch `a` and `b` into internal shift registers, set `idx`=0, set carry register per Configuration (0 by default), then go to RUN. `start`=0 stays in IDLE.
- RUN, each cycle:
  - The shared full adder takes A[0], B[0] and carry from the shift-register LSBs.
  - The sum bit shifts into the MSB of the internal result shift register.
  - Carry register takes the cell's carry out.
  - Operand registers shift right by one; `idx` increments.
- RUN exit: at `idx`=WIDTH-1 the next state is DONE. The internal result is copied to `sum` and the final carry to `c_out` at that same edge.
- DONE: lasts exactly one cycle with `done`=1. If `start`=1, the next request is accepted at once (back-to-back, straight to RUN). Otherwise the FSM goes to IDLE.
- `start` in RUN is ignored and not queued; `a` and `b` changes in RUN have no effect.
- `sum` and `c_out` change only at the edge entering DONE. They hold their value through IDLE and through the following RUN.
- Arithmetic: `{c_out,sum}` = a + b (+ carry-in) mod 2^(WIDTH+1); no overflow flag.
- Reset mid-operation: the FSM returns to IDLE immediately and the in-flight result is discarded. No `done` is issued for it.

## Timing
- Reset values: FSM=IDLE, `busy`=0, `done`=0, `sum`=0, `c_out`=0. Internal registers are also 0.
- Reset is asynchronous on assertion. Deassertion must be synchronous to `clk`; the first `start` is accepted at the first rising edge with `rst_n`=1.
- Call the accepting edge E0. `busy`=1 during the cycles after E0 through E(WIDTH-1).
- At edge E(WIDTH): `sum`/`c_out` update, `busy`=0 and `done`=1 for one cycle.
- Latency from the accepting edge to `done` is WIDTH cycles.
- Throughput with back-to-back requests is one result per WIDTH+1 cycles. `busy` then rises at E(WIDTH+1), i.e. the edge after E(WIDTH).
- `busy` and `done` are never high in the same cycle.

## Configuration
- `SERIAL_ADD_SUB_EN` defined:
  - Adds input `sub` (1 bit), captured with the operands.
  - `sub`=1: the B shift register loads ~b and the carry register loads 1. The block computes a − b; `c_out`=1 means no borrow.
  - `sub`=0: identical to plain add.
- Not defined: no `sub` port; carry register always loads 0; add only.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, `start` pulse in IDLE -> `done` exactly 8 cycles after the accepting edge; `sum`=0x96, `c_out`=0; `busy` high for 8 cycles.
- a=0xFF, b=0x01 -> `sum`=0x00, `c_out`=1; then a=0x00, b=0x00 -> `sum`=0x00, `c_out`=0.
- `start` with a=0x11, b=0x22 held high through RUN and DONE with new operands a=0x01, b=0x01 -> first result 0x33. The second request is accepted only in DONE and gives 0x02. `sum` holds 0x33 through the second RUN.
- `rst_n` pulled low at RUN cycle 3 -> immediate IDLE, `busy`=0, `sum`=0. No `done` follows; the next request completes normally.
- Hold `start`=0 for 20 cycles after reset -> `busy`=0, `done`=0 throughout, outputs stay 0.
- With `SERIAL_ADD_SUB_EN`:
  - a=0x10, b=0x01, `sub`=1 -> `sum`=0x0F, `c_out`=1.
  - a=0x01, b=0x02, `sub`=1 -> `sum`=0xFF, `c_out`=0.
